fifo_rr_push_arbiter: RTL and testbench

- Shares the write port of one fifo_dds_top instance between N_REQ producers.
- Each producer uses a valid/ready handshake. The block picks an owner by round-robin, lets it push up to QUANTUM beats, then re-arbitrates.
- Drives the FIFO's push/write_data and obeys its full flag, so no beat is ever pushed into a full FIFO.

---
 rtl/fifo_arb_pkg.sv | 40 ++++
 rtl/fifo_rr_pick.sv | 27 ++
 rtl/fifo_rr_push_arbiter.sv | 139 +++++++++++++
 tb/tb_fifo_rr_push_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and the round-robin scan helper for the
// FIFO push arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Widest requester vector the scan helper handles.
  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid[n-1:0], scanning start, start+1, ... mod n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                       input int                start,
                                       input int                n);
    rr_pick_t r;
    int       j;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (k < n) begin
        j = start + k;
        if (j >= n) j = j - n;
        if (!r.found && valid[j[RR_IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = j[RR_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// fifo_rr_pick: combinational round-robin priority scan over N_REQ
// valid bits, starting at index start.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    start,
  output logic             found,
  output logic [IW-1:0]    idx
);

  rr_pick_t pick_r;
  logic     pick_unused;

  // Scan is pure combinational; start is always below N_REQ.
  always_comb begin
    pick_r = rr_pick(RR_MAX'(valid), int'(start), N_REQ);
  end

  assign found       = pick_r.found;
  assign idx         = pick_r.idx[IW-1:0];
  assign pick_unused = &{1'b0, pick_r.idx};

endmodule

// File: rtl/fifo_rr_push_arbiter.sv
// fifo_rr_push_arbiter: shares one FIFO write port between N_REQ
// valid/ready producers. Round-robin ownership, up to QUANTUM beats per
// grant, never pushes into a full FIFO.
// Optional: define FIFO_ARB_DEBUG_EN to add the debug[31:0] status port
// (push count, owner, state, beat count).
//
// state | meaning
// IDLE  | no owner; arbitrate when any request is valid (one-cycle bubble)
// GRANT | owner may push; re-arbitrate without bubble on release
module fifo_rr_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int QUANTUM = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_push,
  output logic [WIDTH-1:0]         fifo_write_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
`ifdef FIFO_ARB_DEBUG_EN
  output logic                     busy,
  output logic [31:0]              debug
`else
  output logic                     busy
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(QUANTUM + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(QUANTUM - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

  arb_state_t       state, state_nxt;
  logic [IW-1:0]    owner, owner_nxt;
  logic [IW-1:0]    rr_ptr, rr_ptr_nxt;
  logic [CW-1:0]    beat_cnt, beat_cnt_nxt;
  logic [IW-1:0]    owner_inc;
  logic [IW-1:0]    scan_start;
  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic             owner_valid;
  logic             beat;
  logic             release_grant;
  logic [N_REQ-1:0] ready_c;

  assign owner_inc  = (owner == IDX_LAST) ? '0 : owner + 1'b1;
  assign scan_start = (state == IDLE) ? rr_ptr : owner_inc;

  fifo_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .valid (req_valid),
    .start (scan_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state, grant hand-off and per-cycle handshake decode.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    beat_cnt_nxt  = beat_cnt;
    ready_c       = '0;
    owner_valid   = req_valid[owner];
    beat          = 1'b0;
    release_grant = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt    = GRANT;
          owner_nxt    = pick_idx;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        ready_c[owner] = ~fifo_full;
        beat           = owner_valid & ~fifo_full;
        release_grant  = (beat && (beat_cnt == CNT_LAST)) || !owner_valid;
        if (release_grant) begin
          // Owner's own valid is low on an idle release, so the scan
          // naturally skips it; on a quantum release it is scanned last.
          rr_ptr_nxt   = owner_inc;
          beat_cnt_nxt = '0;
          if (pick_found) owner_nxt = pick_idx;
          else            state_nxt = IDLE;
        end else if (beat) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Gated by rst so nothing handshakes during the reset cycle.
  assign req_ready       = ready_c & {N_REQ{rst}};
  assign fifo_push       = beat & rst;
  assign fifo_write_data = req_data[int'(owner)*WIDTH +: WIDTH];
  assign grant_id        = owner;
  assign busy            = (state == GRANT);

`ifdef FIFO_ARB_DEBUG_EN
  logic [15:0] push_total;

  // Wrapping count of beats pushed into the FIFO.
  always_ff @(posedge clk) begin
    if (!rst)           push_total <= '0;
    else if (fifo_push) push_total <= push_total + 16'd1;
  end

  assign debug = {push_total,
                  {(8 - IW){1'b0}}, owner,
                  (state == GRANT),
                  {(7 - CW){1'b0}}, beat_cnt};
`endif

endmodule

// File: tb/tb_fifo_rr_push_arbiter.sv
// tb_fifo_rr_push_arbiter: directed test of the round-robin FIFO push
// arbiter (N_REQ=4, WIDTH=8, QUANTUM=4) with hand-computed push order.
module tb_fifo_rr_push_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_push;
  logic [7:0]  fifo_write_data;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef FIFO_ARB_DEBUG_EN
  logic [31:0] debug;
`endif

  int total = 0;
  int bad   = 0;
  int head [4];
  int exp_next [4];
  int base [4] = '{32'hA0, 32'hB0, 32'hC0, 32'hD0};
  int n_push;

  fifo_rr_push_arbiter #(.N_REQ(4), .WIDTH(8), .QUANTUM(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .fifo_push       (fifo_push),
    .fifo_write_data (fifo_write_data),
    .grant_id        (grant_id),
`ifdef FIFO_ARB_DEBUG_EN
    .busy            (busy),
    .debug           (debug)
`else
    .busy            (busy)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Producers present data base+1+head; head advances on handshake.
  task automatic drive_data();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(base[i] + 1 + head[i]);
  endtask

  // One clock: apply inputs, check outputs before the edge, then step.
  // ep: expected push, ed: expected data, eg/er: grant/ready (-1 = skip).
  task automatic cyc(input string tag, input logic [3:0] v, input logic full,
                     input int ep, input int ed, input int eg, input int er);
    logic [3:0] hs;
    req_valid = v;
    fifo_full = full;
    #1;
    chk_val({tag, ":push"}, 32'(fifo_push), 32'(ep));
    if (ep != 0) chk_val({tag, ":data"}, 32'(fifo_write_data), 32'(ed));
    if (eg >= 0) chk_val({tag, ":gid"}, 32'(grant_id), 32'(eg));
    if (er >= 0) chk_val({tag, ":ready"}, 32'(req_ready), 32'(er));
    hs = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) head[i]++;
    drive_data();
  endtask

  task automatic beat(input string tag, input logic [3:0] v, input int o);
    cyc(tag, v, 1'b0, 1, exp_next[o], o, 1 << o);
    exp_next[o]++;
  endtask

  task automatic do_reset(input string tag);
    rst       = 1'b0;
    req_valid = 4'b0000;
    fifo_full = 1'b0;
    @(posedge clk);
    #1;
    chk_val({tag, ":push"}, 32'(fifo_push), 32'd0);
    chk_val({tag, ":ready"}, 32'(req_ready), 32'd0);
    chk_val({tag, ":busy"}, 32'(busy), 32'd0);
    chk_val({tag, ":gid"}, 32'(grant_id), 32'd0);
`ifdef FIFO_ARB_DEBUG_EN
    chk_val({tag, ":debug"}, debug, 32'd0);
`endif
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      head[i]     = 0;
      exp_next[i] = base[i] + 1;
    end
    rst       = 1'b0;
    req_valid = 4'b0000;
    fifo_full = 1'b0;
    drive_data();
    @(posedge clk);
    #1;
    do_reset("rst0");

    // Single requester: bubble, 4 beats, back-to-back re-grant.
    cyc("t1_bubble", 4'b0001, 1'b0, 0, 0, 0, 0);
    chk_val("t1_bubble:busy", 32'(busy), 32'd1);
    for (int k = 0; k < 6; k++) beat("t1_beat", 4'b0001, 0);
    cyc("t1_rel", 4'b0000, 1'b0, 0, 0, 0, 1);
    chk_val("t1_idle:busy", 32'(busy), 32'd0);

    do_reset("rst1");

    // All valid: order 0,1,2,3,0 with 4 beats each, one bubble only.
    cyc("t2_bubble", 4'b1111, 1'b0, 0, 0, -1, 0);
    n_push = 0;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
`ifdef FIFO_ARB_DEBUG_EN
        if (n_push == 10)
          chk_val("dbg_10", debug, {16'd10, 8'd2, 1'b1, 7'd2});
`endif
        beat("t2_rr", 4'b1111, r % 4);
        n_push++;
      end
    end

    // Owner 1 stalled by a full FIFO mid-grant; remaining beats resume.
    beat("t3_pre", 4'b1111, 1);
    beat("t3_pre", 4'b1111, 1);
    for (int k = 0; k < 5; k++) cyc("t3_full", 4'b1111, 1'b1, 0, 0, 1, 0);
    beat("t3_post", 4'b1111, 1);
    beat("t3_post", 4'b1111, 1);

    // Owner 2 drops valid after 2 beats; scan 3,0 picks requester 0.
    beat("t4_own2", 4'b1111, 2);
    beat("t4_own2", 4'b1111, 2);
    cyc("t4_drop", 4'b0001, 1'b0, 0, 0, 2, 4'b0100);
    beat("t4_own0", 4'b0001, 0);

    // Owner 0 goes idle, hand-off to 3; reset at beat_cnt==2.
    cyc("t5_sw", 4'b1000, 1'b0, 0, 0, 0, 1);
    beat("t5_own3", 4'b1000, 3);
    beat("t5_own3", 4'b1000, 3);
    rst = 1'b0;
    #1;
    chk_val("t5_rstcyc:push", 32'(fifo_push), 32'd0);
    chk_val("t5_rstcyc:ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_val("t5_after:busy", 32'(busy), 32'd0);
    chk_val("t5_after:gid", 32'(grant_id), 32'd0);
    chk_val("t5_after:push", 32'(fifo_push), 32'd0);
`ifdef FIFO_ARB_DEBUG_EN
    chk_val("t5_after:debug", debug, 32'd0);
`endif
    cyc("t5_idle", 4'b1000, 1'b0, 0, 0, 0, 0);
    beat("t5_regrant", 4'b1000, 3);
    cyc("t5_end", 4'b0000, 1'b0, 0, 0, 3, 4'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
